cp0_timer_irq: RTL and testbench
================================

# cp0_timer_irq

Parametrised timer and interrupt-collection unit for the CP0 register file. It holds Count and up to four Compare channels, and synchronises the external hardware interrupt lines with a per-line level/edge mode. It produces the registered Cause.IP[7:2] vector and the timer-interrupt indication for the exception logic. It sits beside the CP0 register file on the same mtc0/mfc0 address bus ({rd,sel}) and replaces that file's fixed single-compare timer.

## Interface
- NUM_CMP, 1: number of Compare channels (1..4), at (11,0)..(11,NUM_CMP-1).
- PRESCALE, 2: clk cycles per Count increment (>=1).
- NUM_HWINT, 6: number of external interrupt lines (1..6), mapped to IP[2+i].
- SYNC_STAGES, 2: synchroniser depth for external lines (>=2).
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  reset, asynchronous active-low.
- int_in  in  NUM_HWINT  external interrupt lines, asynchronous to clk.
- wr_en  in  1  mtc0 write strobe.
- wr_addr  in  8  write address {rd[4:0],sel[2:0]}.
- wr_data  in  32  write data.
- rd_addr  in  8  read address {rd,sel}.
- rd_data  out  32  combinational read data; 0 for unmapped addresses.
- ip  out  6  Cause.IP[7:2]: bit i = hw line i; bit 5 additionally ORs ti.
- timer_pending  out  NUM_CMP  per-channel sticky compare-match flags.
- ti  out  1  OR of timer_pending (Cause.TI).

## Operation
- Register map:
  - Count: 8'h48.
  - Compare k: 8'h58+k.
  - IntMode: 8'hB0, read/write.
    - bits[NUM_HWINT-1:0]: edge mode (1 = edge).
    - bits[NUM_HWINT+15:16]: read = edge latches, write 1 = clear.
    - Other bits read 0.
- Compare k with k>=NUM_CMP reads 0; writes to it are ignored.
- Reset values:
  - count = 0; prescaler = 0.
  - compare[all] = 32'hFFFFFFFF.
  - pending = 0; mode = 0; edge latches = 0; sync/prev flops = 0.
  - Hence ip = 0, ti = 0, timer_pending = 0.
- Prescaler counts 0..PRESCALE-1. At PRESCALE-1 it wraps to 0 and count increments mod 2^32 (FFFFFFFF -> 0).
  - PRESCALE = 1: count increments every cycle.
- Count write: count <= wr_data and prescaler <= 0. No increment occurs that cycle.
- Compare match, each cycle for each k:
  - Next pending[k] = write_compare_k ? 0 : pending[k] | (count == compare[k]).
  - Comparison uses current register values, not the values being written.
  - A compare write in the same cycle as a match clears the flag; the write wins.
- External lines: each passes through SYNC_STAGES flops to give s[i]; prev[i] <= s[i].
  - Level mode: ip[i] = s[i].
  - Edge mode: latch[i] sets on s[i] & ~prev[i] and clears on IntMode write with bit 16+i = 1.
    - Set wins over clear in the same cycle.
    - ip[i] = latch[i].
  - Changing the mode does not alter the latches. A level line switched to edge mode reports only later rising edges.
- ip[5] = hw5 | ti, where hw5 is 0 if NUM_HWINT < 6. Missing lines i >= NUM_HWINT read 0.
- Reads are combinational from registers. A write and a read of the same address in one cycle return the old value.

## Timing
- Count: after resetn rises, the first increment lands on the PRESCALE-th rising edge. Later increments follow every PRESCALE edges.
- Timer: if count becomes equal to compare[k] at edge n, pending[k] and ti are high after edge n+1.
  - pending[k] stays high until Compare k is written. Count continuing past the match does not clear it.
- Level line: a change on int_in appears on ip after SYNC_STAGES edges. It is a combinational function of the last synchroniser flop.
- Edge line: a rising edge appears on ip after SYNC_STAGES+1 edges and holds until cleared.
- Clearing via IntMode takes effect on ip after the write edge.
- Asserting resetn low mid-operation clears all state immediately (asynchronously), including a partially synchronised input. Outputs go to their reset values without waiting for clk.

## Test plan
- Reset, then PRESCALE=2, NUM_CMP=2: write Compare0=5. Expect count=5 at edge 10 after the write, pending[0]=1 and ti=1 and ip[5]=1 one edge later. Expect pending[1]=0.
- Write Compare0 on the same edge a match occurs -> pending[0] stays 0. Write Count=FFFFFFFE -> count wraps to 0 after 2*PRESCALE edges.
- Level line 2: hold int_in[2]=1 -> ip[2]=1 after 2 edges (SYNC_STAGES=2). Drop it -> ip[2]=0 two edges later.
- Edge line 3: IntMode=0x8, pulse int_in[3] for 3 cycles -> ip[3]=1 at SYNC_STAGES+1 and stays 1.
  - Read 8'hB0 -> 0x00080008.
  - Write 0x00080008 -> ip[3]=0.
  - A rising edge in the same cycle as the clear -> stays 1.
- Unmapped/absent channels: read Compare3 with NUM_CMP=2 -> 0. Write it -> no state change. Read 8'h00 -> 0.
- Mid-run reset: with pending=1 and an edge latch set, pulse resetn low between clock edges -> ip=0, ti=0, count=0 immediately. Compare reads FFFFFFFF.

Source files
------------

// File: rtl/cp0_timer_irq.sv
// CP0 timer and interrupt collection: Count with prescaler, up to four sticky
// Compare channels, and synchronised external lines with per-line level/edge mode.
`timescale 1ns/1ps

module cp0_timer_irq #(
    parameter int NUM_CMP     = 1,
    parameter int PRESCALE    = 2,
    parameter int NUM_HWINT   = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NUM_HWINT-1:0] int_in,
    input  logic                 wr_en,
    input  logic [7:0]           wr_addr,
    input  logic [31:0]          wr_data,
    input  logic [7:0]           rd_addr,
    output logic [31:0]          rd_data,
    output logic [5:0]           ip,
    output logic [NUM_CMP-1:0]   timer_pending,
    output logic                 ti
);

    localparam logic [7:0] ADDR_COUNT   = 8'h48;
    localparam logic [7:0] ADDR_CMP0    = 8'h58;
    localparam logic [7:0] ADDR_INTMODE = 8'hB0;
    localparam int         PW           = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);

    // wr_en is a single-cycle strobe sampled on the rising edge; there is no
    // back-pressure, every strobed write is accepted in that cycle.
    logic               wr_count;
    logic               wr_intmode;
    logic [NUM_CMP-1:0] wr_cmp;

    always_comb begin
        wr_count   = wr_en && (wr_addr == ADDR_COUNT);
        wr_intmode = wr_en && (wr_addr == ADDR_INTMODE);
        wr_cmp     = '0;
        for (int k = 0; k < NUM_CMP; k++) begin
            wr_cmp[k] = wr_en && (wr_addr == ADDR_CMP0 + 8'(k));
        end
    end

    // Count and prescaler
    logic [PW-1:0] prescale_q;
    logic [31:0]   count_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prescale_q <= '0;
            count_q    <= '0;
        end else if (wr_count) begin
            prescale_q <= '0;
            count_q    <= wr_data;
        end else if (prescale_q == PRE_LAST) begin
            prescale_q <= '0;
            count_q    <= count_q + 32'd1;
        end else begin
            prescale_q <= prescale_q + PW'(1);
        end
    end

    // Compare channels; a write to Compare k clears its flag even on a match cycle.
    logic [31:0]        compare_q [NUM_CMP];
    logic [NUM_CMP-1:0] pending_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < NUM_CMP; k++) begin
                compare_q[k] <= '1;
            end
            pending_q <= '0;
        end else begin
            for (int k = 0; k < NUM_CMP; k++) begin
                if (wr_cmp[k]) begin
                    compare_q[k] <= wr_data;
                    pending_q[k] <= 1'b0;
                end else if (count_q == compare_q[k]) begin
                    pending_q[k] <= 1'b1;
                end
            end
        end
    end

    assign timer_pending = pending_q;
    assign ti            = |pending_q;

    // External line synchroniser, edge detector and edge latches
    logic [NUM_HWINT-1:0] sync_q [SYNC_STAGES];
    logic [NUM_HWINT-1:0] prev_q;
    logic [NUM_HWINT-1:0] mode_q;
    logic [NUM_HWINT-1:0] latch_q;
    logic [NUM_HWINT-1:0] sync_s;
    logic [NUM_HWINT-1:0] rise;
    logic [NUM_HWINT-1:0] clr;

    assign sync_s = sync_q[SYNC_STAGES-1];
    // Only lines already in edge mode latch, so a line switched to edge mode
    // reports rising edges from then on, never stale history.
    assign rise   = mode_q & sync_s & ~prev_q;
    assign clr    = wr_intmode ? wr_data[16 +: NUM_HWINT] : '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            prev_q  <= '0;
            mode_q  <= '0;
            latch_q <= '0;
        end else begin
            sync_q[0] <= int_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            prev_q  <= sync_s;
            latch_q <= rise | (latch_q & ~clr);
            if (wr_intmode) begin
                mode_q <= wr_data[NUM_HWINT-1:0];
            end
        end
    end

    // Cause.IP[7:2]; lines beyond NUM_HWINT stay 0, IP7 also carries the timer.
    logic [NUM_HWINT-1:0] line_ip;
    logic [5:0]           hw_ip;

    assign line_ip = (mode_q & latch_q) | (~mode_q & sync_s);

    always_comb begin
        hw_ip                  = '0;
        hw_ip[NUM_HWINT-1:0]   = line_ip;
    end

    assign ip = hw_ip | {ti, 5'b0};

    // Read mux, combinational from registers
    always_comb begin
        rd_data = '0;
        case (rd_addr)
            ADDR_COUNT: rd_data = count_q;
            ADDR_INTMODE: begin
                rd_data[NUM_HWINT-1:0]   = mode_q;
                rd_data[16 +: NUM_HWINT] = latch_q;
            end
            default: begin
                for (int k = 0; k < NUM_CMP; k++) begin
                    if (rd_addr == ADDR_CMP0 + 8'(k)) begin
                        rd_data = compare_q[k];
                    end
                end
            end
        endcase
    end

endmodule

// File: tb/tb_cp0_timer_irq.sv
// Bench for cp0_timer_irq: directed scenarios plus random traffic, checked by a
// scoreboard fed from an arithmetic reference model.
`timescale 1ns/1ps

module tb_cp0_timer_irq;

  localparam int NUM_CMP     = 2;
  localparam int PRESCALE    = 2;
  localparam int NUM_HWINT   = 6;
  localparam int SYNC_STAGES = 2;
  localparam int EW          = 32 + 1 + NUM_CMP + 6;

  // clock / reset
  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic [NUM_HWINT-1:0] int_in;
  logic                 wr_en;
  logic [7:0]           wr_addr;
  logic [31:0]          wr_data;
  logic [7:0]           rd_addr;
  logic [31:0]          rd_data;
  logic [5:0]           ip;
  logic [NUM_CMP-1:0]   timer_pending;
  logic                 ti;

  cp0_timer_irq #(
    .NUM_CMP(NUM_CMP), .PRESCALE(PRESCALE), .NUM_HWINT(NUM_HWINT), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk), .resetn(resetn), .int_in(int_in), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data), .ip(ip),
    .timer_pending(timer_pending), .ti(ti)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_pushed = 0;
  int n_popped = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;

  // reference model: count = base + elapsed_edges / PRESCALE
  logic [31:0]        m_base;
  int unsigned        m_cyc;
  logic [31:0]        m_cmp [NUM_CMP];
  logic [NUM_CMP-1:0] m_pend;
  logic [5:0]         m_mode;
  logic [5:0]         m_latch;
  logic [5:0]         hist[$];   // hist[0] = int_in sampled at the latest edge
  logic [5:0]         cur_int;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] m_count();
    return m_base + 32'(m_cyc / PRESCALE);
  endfunction

  function automatic void model_reset();
    m_base  = '0;
    m_cyc   = 0;
    for (int k = 0; k < NUM_CMP; k++) m_cmp[k] = '1;
    m_pend  = '0;
    m_mode  = '0;
    m_latch = '0;
    hist.delete();
    for (int i = 0; i <= SYNC_STAGES; i++) hist.push_back(6'b0);
  endfunction

  function automatic logic [5:0] model_ip();
    logic [5:0] s = hist[SYNC_STAGES-1];
    logic [5:0] r;
    for (int i = 0; i < 6; i++) r[i] = m_mode[i] ? m_latch[i] : s[i];
    r[5] = r[5] | (|m_pend);
    return r;
  endfunction

  function automatic logic [31:0] model_rd(input logic [7:0] a);
    logic [31:0] r = '0;
    if (a == 8'h48) r = m_count();
    else if (a == 8'hB0) r = {10'b0, m_latch, 10'b0, m_mode};
    else for (int k = 0; k < NUM_CMP; k++) if (a == 8'h58 + 8'(k)) r = m_cmp[k];
    return r;
  endfunction

  function automatic void model_edge(input logic we, input logic [7:0] wa,
                                     input logic [31:0] wd, input logic [5:0] ii);
    logic [31:0] c   = m_count();
    logic [5:0]  s_b = hist[SYNC_STAGES-1];
    logic [5:0]  p_b = hist[SYNC_STAGES];
    logic [5:0]  up  = s_b & ~p_b & m_mode;
    for (int k = 0; k < NUM_CMP; k++) begin
      if (we && wa == 8'h58 + 8'(k)) begin
        m_pend[k] = 1'b0;
        m_cmp[k]  = wd;
      end else if (c == m_cmp[k]) begin
        m_pend[k] = 1'b1;
      end
    end
    if (we && wa == 8'hB0) begin
      m_latch = up | (m_latch & ~wd[21:16]);
      m_mode  = wd[5:0];
    end else begin
      m_latch = m_latch | up;
    end
    hist.push_front(ii);
    void'(hist.pop_back());
    if (we && wa == 8'h48) begin
      m_base = wd;
      m_cyc  = 0;
    end else begin
      m_cyc++;
    end
  endfunction

  // driver: one clock cycle; expectation for this cycle's outputs is queued first
  task automatic cycle(input logic we, input logic [7:0] wa, input logic [31:0] wd,
                       input logic [7:0] ra);
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    rd_addr = ra;
    int_in  = cur_int;
    exp_q.push_back({model_rd(ra), |m_pend, m_pend, model_ip()});
    n_pushed++;
    @(posedge clk);
    model_edge(we, wa, wd, cur_int);
    #1;
  endtask

  task automatic idle(input int n, input logic [7:0] ra);
    repeat (n) cycle(1'b0, 8'h00, 32'h0, ra);
  endtask

  // monitor
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      n_popped++;
      check("ip", 32'(ip), 32'(mon_e[5:0]));
      check("timer_pending", 32'(timer_pending), 32'(mon_e[6 +: NUM_CMP]));
      check("ti", 32'(ti), 32'(mon_e[6+NUM_CMP]));
      check($sformatf("rd_data@%h", rd_addr), rd_data, mon_e[EW-1 -: 32]);
    end
  end

  logic [7:0] addr_tab [7] = '{8'h48, 8'h58, 8'h59, 8'h5A, 8'h5B, 8'hB0, 8'h00};

  function automatic logic [7:0] addr_pick();
    int unsigned i = $urandom_range(0, 7);
    if (i == 7) return 8'($urandom());
    return addr_tab[i];
  endfunction

  logic        r_we;
  logic [7:0]  r_wa, r_ra;
  logic [31:0] r_wd;

  initial begin
    int_in = '0; wr_en = 0; wr_addr = '0; wr_data = '0; rd_addr = 8'h58;
    cur_int = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    #1;
    check("reset_cmp0", rd_data, 32'hFFFF_FFFF);
    check("reset_ip", 32'(ip), 32'h0);
    check("reset_ti", 32'(ti), 32'h0);
    check("reset_pending", 32'(timer_pending), 32'h0);

    // timer match: count reaches 5 ten edges after the Count write
    cycle(1'b1, 8'h48, 32'd0, 8'h48);
    cycle(1'b1, 8'h58, 32'd5, 8'h48);
    idle(9, 8'h48);
    check("count_at_edge10", rd_data, 32'd5);
    check("pending0_before", 32'(timer_pending[0]), 32'd0);
    idle(1, 8'h48);
    check("pending0_set", 32'(timer_pending[0]), 32'd1);
    check("ti_set", 32'(ti), 32'd1);
    check("ip5_timer", 32'(ip[5]), 32'd1);
    check("pending1_clear", 32'(timer_pending[1]), 32'd0);
    idle(4, 8'h48);
    check("pending0_sticky", 32'(timer_pending[0]), 32'd1);

    // compare write on the match cycle wins
    cycle(1'b1, 8'h58, 32'd200, 8'h58);
    cycle(1'b1, 8'h48, 32'd200, 8'h48);
    cycle(1'b1, 8'h58, 32'd300, 8'h58);
    idle(3, 8'h48);
    check("write_wins", 32'(timer_pending[0]), 32'd0);

    // count wraps FFFFFFFE -> 0 after 2*PRESCALE edges
    cycle(1'b1, 8'h48, 32'hFFFF_FFFE, 8'h48);
    idle(4, 8'h48);
    check("count_wrap", rd_data, 32'd0);
    cycle(1'b1, 8'h59, 32'h0000_1000, 8'h59);

    // level line 2
    cur_int[2] = 1'b1;
    idle(1, 8'h00);
    check("lvl_rise_1", 32'(ip[2]), 32'd0);
    idle(1, 8'h00);
    check("lvl_rise_2", 32'(ip[2]), 32'd1);
    cur_int[2] = 1'b0;
    idle(1, 8'h00);
    check("lvl_fall_1", 32'(ip[2]), 32'd1);
    idle(1, 8'h00);
    check("lvl_fall_2", 32'(ip[2]), 32'd0);

    // edge line 3
    cycle(1'b1, 8'hB0, 32'h0000_0008, 8'hB0);
    cur_int[3] = 1'b1;
    idle(2, 8'hB0);
    check("edge_rise_2", 32'(ip[3]), 32'd0);
    idle(1, 8'hB0);
    check("edge_rise_3", 32'(ip[3]), 32'd1);
    cur_int[3] = 1'b0;
    idle(3, 8'hB0);
    check("edge_hold", 32'(ip[3]), 32'd1);
    check("intmode_read", rd_data, 32'h0008_0008);
    cycle(1'b1, 8'hB0, 32'h0008_0008, 8'hB0);
    check("edge_clear", 32'(ip[3]), 32'd0);
    cur_int[3] = 1'b1;
    idle(2, 8'hB0);
    cycle(1'b1, 8'hB0, 32'h0008_0008, 8'hB0);
    check("set_beats_clear", 32'(ip[3]), 32'd1);
    cur_int[3] = 1'b0;
    cycle(1'b1, 8'hB0, 32'h0000_0000, 8'hB0);
    check("level_keeps_latch", rd_data, 32'h0008_0000);
    // level activity must not show up after switching to edge mode
    cycle(1'b1, 8'hB0, 32'h0008_0000, 8'hB0);
    cur_int[3] = 1'b1;
    idle(3, 8'hB0);
    cur_int[3] = 1'b0;
    idle(3, 8'hB0);
    cycle(1'b1, 8'hB0, 32'h0000_0008, 8'hB0);
    idle(2, 8'hB0);
    check("no_stale_edge", 32'(ip[3]), 32'd0);

    // absent / unmapped registers
    cycle(1'b0, 8'h00, 32'h0, 8'h5B);
    check("cmp3_reads0", rd_data, 32'd0);
    cycle(1'b1, 8'h5B, 32'hDEAD_BEEF, 8'h5B);
    check("cmp3_write_ignored", rd_data, 32'd0);
    cycle(1'b0, 8'h00, 32'h0, 8'h00);
    check("addr00_reads0", rd_data, 32'd0);
    cycle(1'b0, 8'h00, 32'h0, 8'h58);
    check("cmp0_unchanged", rd_data, 32'd300);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) cur_int[$urandom_range(0, 5)] ^= 1'b1;
      r_we = ($urandom_range(0, 3) == 0);
      r_wa = addr_pick();
      r_wd = $urandom();
      if (r_wa == 8'h48 && $urandom_range(0, 1) == 1)
        r_wd = m_cmp[$urandom_range(0, NUM_CMP-1)] - 32'($urandom_range(0, 5));
      if ((r_wa == 8'h58 || r_wa == 8'h59) && $urandom_range(0, 1) == 1)
        r_wd = m_count() + 32'($urandom_range(0, 6));
      r_ra = addr_pick();
      cycle(r_we, r_wa, r_wd, r_ra);
    end

    // asynchronous reset mid-run with a pending timer and a set edge latch
    cur_int = '0;
    idle(4, 8'h00);
    cycle(1'b1, 8'hB0, 32'h003F_0008, 8'hB0);
    cycle(1'b1, 8'h48, 32'd10, 8'h48);
    cycle(1'b1, 8'h58, 32'd10, 8'h58);
    cur_int[3] = 1'b1;
    idle(4, 8'h58);
    check("prereset_pending", 32'(timer_pending[0]), 32'd1);
    check("prereset_latch", 32'(ip[3]), 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("async_ip", 32'(ip), 32'd0);
    check("async_ti", 32'(ti), 32'd0);
    check("async_pending", 32'(timer_pending), 32'd0);
    check("async_cmp0", rd_data, 32'hFFFF_FFFF);
    rd_addr = 8'h48;
    #1 check("async_count", rd_data, 32'd0);
    rd_addr = 8'hB0;
    #1 check("async_intmode", rd_data, 32'd0);
    model_reset();
    cur_int = '0;
    int_in  = '0;
    @(posedge clk);
    #1 resetn = 1'b1;
    idle(6, 8'h48);
    check("post_reset_count", rd_data, 32'd3);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("pushed_eq_popped", 32'(n_popped), 32'(n_pushed));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
